// File: rtl/pwm_fade_ctrl_if.sv
// Command and register-bus bundle between the command source, pwm_fade_ctrl and the pwm block.
interface pwm_fade_ctrl_if #(
    parameter int unsigned IW = 16
);
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [7:0]    cmd_target_i;
    logic [7:0]    cmd_step_i;
    logic [IW-1:0] cmd_interval_i;
    logic          abort_i;
    logic [7:0]    b_addr_o;
    logic [7:0]    b_data_o;
    logic          b_write_o;
    logic [7:0]    duty_o;
    logic          busy_o;
    logic          done_o;

    // Fade sequencer side: consumes commands, drives the pwm register bus.
    modport master (
        input  cmd_valid_i, cmd_target_i, cmd_step_i, cmd_interval_i, abort_i,
        output cmd_ready_o, b_addr_o, b_data_o, b_write_o, duty_o, busy_o, done_o
    );

    // Command source / observer side.
    modport slave (
        output cmd_valid_i, cmd_target_i, cmd_step_i, cmd_interval_i, abort_i,
        input  cmd_ready_o, b_addr_o, b_data_o, b_write_o, duty_o, busy_o, done_o
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps the pwm duty register toward a commanded target, one
// step per write, with a programmable idle interval before each write.
// Optional feature macro: PWM_FADE_CFG_WRITE_EN (one config write after reset).
module pwm_fade_ctrl #(
    parameter logic [7:0]  DUTY_ADDR = 8'h01,
    parameter logic [7:0]  INIT_DUTY = 8'h00,
`ifdef PWM_FADE_CFG_WRITE_EN
    parameter logic [7:0]  CFG_ADDR  = 8'h00,
    parameter logic [7:0]  CFG_VALUE = 8'h82,
`endif
    parameter int unsigned IW        = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pwm_fade_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_GAP,
`ifdef PWM_FADE_CFG_WRITE_EN
        S_CFG_WR,
        S_CFG_GAP,
`endif
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [7:0]    target_q, target_d;
    logic [7:0]    step_q, step_d;
    logic [IW-1:0] interval_q, interval_d;
    logic [IW-1:0] cnt, cnt_d;
    logic          abort_q, abort_d;
    logic [7:0]    b_addr, b_addr_d;
    logic [7:0]    b_data, b_data_d;
    logic          b_write, b_write_d;
    logic [7:0]    duty, duty_d;
    logic          busy, busy_d;
    logic          done, done_d;
    logic [7:0]    next_duty;
`ifdef PWM_FADE_CFG_WRITE_EN
    logic          cfg_done, cfg_done_d;
`endif

    // Next duty: move toward target by step (0 acts as 1), clamping to target in 9-bit math.
    always_comb begin
        logic [7:0] step_eff;
        logic [8:0] diff;
        step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
        if (target_q > duty) begin
            diff      = 9'(target_q) - 9'(duty);
            next_duty = (diff <= 9'(step_eff)) ? target_q : 8'(duty + step_eff);
        end else begin
            diff      = 9'(duty) - 9'(target_q);
            next_duty = (diff <= 9'(step_eff)) ? target_q : 8'(duty - step_eff);
        end
    end

    // Next-state and next-output logic; bus outputs are registered on state entry.
    always_comb begin
        state_d    = state;
        target_d   = target_q;
        step_d     = step_q;
        interval_d = interval_q;
        cnt_d      = cnt;
        abort_d    = abort_q | (bus.abort_i && (state != S_IDLE));
        b_addr_d   = b_addr;
        b_data_d   = b_data;
        b_write_d  = 1'b0;
        duty_d     = duty;
`ifdef PWM_FADE_CFG_WRITE_EN
        cfg_done_d = cfg_done;
`endif
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    target_d   = bus.cmd_target_i;
                    step_d     = bus.cmd_step_i;
                    interval_d = bus.cmd_interval_i;
                    cnt_d      = bus.cmd_interval_i;
`ifdef PWM_FADE_CFG_WRITE_EN
                    if (!cfg_done) begin
                        state_d    = S_CFG_WR;
                        b_write_d  = 1'b1;
                        b_addr_d   = CFG_ADDR;
                        b_data_d   = CFG_VALUE;
                        cfg_done_d = 1'b1;
                    end else
`endif
                    if (bus.cmd_target_i == duty) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (abort_q) begin
                    state_d = S_DONE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - IW'(1);
                end else begin
                    state_d   = S_WRITE;
                    b_write_d = 1'b1;
                    b_addr_d  = DUTY_ADDR;
                    b_data_d  = next_duty;
                    duty_d    = next_duty;
                end
            end
            S_WRITE: state_d = S_GAP;
            S_GAP: begin
                if ((duty == target_q) || abort_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = interval_q;
                end
            end
`ifdef PWM_FADE_CFG_WRITE_EN
            S_CFG_WR: state_d = S_CFG_GAP;
            S_CFG_GAP: state_d = (target_q == duty) ? S_DONE : S_WAIT;
`endif
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            target_q   <= 8'd0;
            step_q     <= 8'd0;
            interval_q <= '0;
            cnt        <= '0;
            abort_q    <= 1'b0;
            b_addr     <= 8'd0;
            b_data     <= 8'd0;
            b_write    <= 1'b0;
            duty       <= INIT_DUTY;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PWM_FADE_CFG_WRITE_EN
            cfg_done   <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            target_q   <= target_d;
            step_q     <= step_d;
            interval_q <= interval_d;
            cnt        <= cnt_d;
            abort_q    <= abort_d;
            b_addr     <= b_addr_d;
            b_data     <= b_data_d;
            b_write    <= b_write_d;
            duty       <= duty_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef PWM_FADE_CFG_WRITE_EN
            cfg_done   <= cfg_done_d;
`endif
        end
    end

    assign bus.cmd_ready_o = (state == S_IDLE);
    assign bus.b_addr_o    = b_addr;
    assign bus.b_data_o    = b_data;
    assign bus.b_write_o   = b_write;
    assign bus.duty_o      = duty;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: fixed command table, hand sequences, and random
// commands checked against a timing/arithmetic reference model.
module tb_pwm_fade_ctrl;
    localparam int unsigned IW        = 16;
    localparam logic [7:0]  DUTY_ADDR = 8'h01;
    localparam logic [7:0]  INIT_DUTY = 8'h00;
    localparam logic [7:0]  CFG_ADDR  = 8'h00;
    localparam logic [7:0]  CFG_VALUE = 8'h82;
`ifdef PWM_FADE_CFG_WRITE_EN
    localparam bit HAS_CFG = 1'b1;
`else
    localparam bit HAS_CFG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_fade_ctrl_if #(.IW(IW)) bus ();

    pwm_fade_ctrl #(
        .DUTY_ADDR(DUTY_ADDR),
        .INIT_DUTY(INIT_DUTY),
        .IW(IW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    typedef struct {
        int tgt;
        int stp;
        int ivl;
        int ab;
        int n_wr;
        int fin;
        int done;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cur_duty;
    bit cfg_pending;
    int exp_off[$], exp_dat[$], exp_adr[$];
    int got_off[$], got_dat[$], got_adr[$];
    int exp_done, got_done, exp_final;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: write k lands at offset s+ivl+1 where WAIT starts at s; abort seen in WAIT or GAP.
    task automatic model(input int d0, input int tgt, input int stp, input int ivl,
                         input int ab, input bit cfg);
        int d, st, s, w;
        d  = d0;
        st = (stp == 0) ? 1 : stp;
        exp_off.delete(); exp_dat.delete(); exp_adr.delete();
        if (cfg) begin
            exp_off.push_back(1); exp_dat.push_back(int'(CFG_VALUE)); exp_adr.push_back(int'(CFG_ADDR));
        end
        if (tgt == d) begin
            exp_done = cfg ? 3 : 1;
        end else begin
            s = cfg ? 3 : 1;
            while (1) begin
                w = s + ivl + 1;
                if (ab >= 1 && ab >= s - 1 && ab <= w - 2) begin
                    exp_done = ab + 2;
                    break;
                end
                if (tgt > d) d = (tgt - d <= st) ? tgt : d + st;
                else         d = (d - tgt <= st) ? tgt : d - st;
                exp_off.push_back(w); exp_dat.push_back(d); exp_adr.push_back(int'(DUTY_ADDR));
                if (d == tgt || (ab >= 1 && ab <= w)) begin
                    exp_done = w + 2;
                    break;
                end
                s = w + 2;
            end
        end
        exp_final = d;
    endtask

    // Issue one command (called at a negedge) and compare the bus trace with the model.
    task automatic run(input int tgt, input int stp, input int ivl, input int ab);
        int n, m;
        model(cur_duty, tgt, stp, ivl, ab, cfg_pending);
        n = 0;
        while (!bus.cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", 64'(bus.cmd_ready_o), 64'(1));
        bus.cmd_valid_i    = 1'b1;
        bus.cmd_target_i   = 8'(tgt);
        bus.cmd_step_i     = 8'(stp);
        bus.cmd_interval_i = IW'(ivl);
        got_off.delete(); got_dat.delete(); got_adr.delete();
        got_done = -1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.cmd_valid_i    = 1'b0;
                bus.cmd_target_i   = 8'($urandom);
                bus.cmd_step_i     = 8'($urandom);
                bus.cmd_interval_i = IW'($urandom);
            end
            bus.abort_i = (c == ab);
            if (bus.b_write_o) begin
                got_off.push_back(c); got_dat.push_back(int'(bus.b_data_o)); got_adr.push_back(int'(bus.b_addr_o));
            end
            if (bus.done_o) begin
                got_done = c;
                break;
            end
        end
        bus.abort_i = 1'b0;
        check("write_count", 64'(got_off.size()), 64'(exp_off.size()));
        m = (got_off.size() < exp_off.size()) ? got_off.size() : exp_off.size();
        for (int i = 0; i < m; i++) begin
            check("write_cycle", 64'(got_off[i]), 64'(exp_off[i]));
            check("write_data", 64'(got_dat[i]), 64'(exp_dat[i]));
            check("write_addr", 64'(got_adr[i]), 64'(exp_adr[i]));
        end
        check("done_cycle", 64'(got_done), 64'(exp_done));
        check("final_duty", 64'(bus.duty_o), 64'(exp_final));
        @(negedge clk);
        check("ready_done_busy_after", 64'({bus.cmd_ready_o, bus.done_o, bus.busy_o}), 64'(3'b100));
        cur_duty    = exp_final;
        cfg_pending = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   adj, adjn, tgt, stp, ivl, ab, n;
        bit   found;
        logic [2:0] dn;

        tbl[0] = '{tgt: 8'h0A, stp: 4,      ivl: 0, ab: -1, n_wr: 3, fin: 8'h0A, done: 10};
        tbl[1] = '{tgt: 8'h00, stp: 8'hFF,  ivl: 3, ab: -1, n_wr: 1, fin: 8'h00, done: 7};
        tbl[2] = '{tgt: 8'h00, stp: 5,      ivl: 7, ab: -1, n_wr: 0, fin: 8'h00, done: 1};
        tbl[3] = '{tgt: 8'hFF, stp: 1,      ivl: 2, ab: 14, n_wr: 3, fin: 8'h03, done: 16};
        tbl[4] = '{tgt: 8'h05, stp: 0,      ivl: 0, ab: -1, n_wr: 2, fin: 8'h05, done: 7};
        tbl[5] = '{tgt: 8'hFE, stp: 8'hC8,  ivl: 1, ab: -1, n_wr: 2, fin: 8'hFE, done: 9};
        tbl[6] = '{tgt: 8'hFF, stp: 8'hFF,  ivl: 0, ab: -1, n_wr: 1, fin: 8'hFF, done: 4};
        tbl[7] = '{tgt: 8'h00, stp: 8'h10,  ivl: 5, ab: 10, n_wr: 1, fin: 8'hEF, done: 12};

        bus.cmd_valid_i = 1'b0; bus.cmd_target_i = 8'h00; bus.cmd_step_i = 8'h00;
        bus.cmd_interval_i = '0; bus.abort_i = 1'b0;

        // Reset for three cycles, then release.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.b_addr_o, bus.b_data_o, bus.b_write_o, bus.done_o, bus.busy_o, bus.duty_o, bus.cmd_ready_o}),
              64'({8'h00, 8'h00, 1'b0, 1'b0, 1'b0, INIT_DUTY, 1'b1}));
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({bus.b_write_o, bus.done_o, bus.busy_o, bus.duty_o, bus.cmd_ready_o}),
              64'({1'b0, 1'b0, 1'b0, INIT_DUTY, 1'b1}));
        cur_duty    = int'(INIT_DUTY);
        cfg_pending = HAS_CFG;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            adj  = cfg_pending ? 2 : 0;
            adjn = cfg_pending ? 1 : 0;
            run(tbl[i].tgt, tbl[i].stp, tbl[i].ivl, tbl[i].ab);
            check("tbl_writes", 64'(got_off.size()), 64'(tbl[i].n_wr + adjn));
            check("tbl_done", 64'(got_done), 64'(tbl[i].done + adj));
            check("tbl_duty", 64'(bus.duty_o), 64'(tbl[i].fin));
        end

        // valid held high with target==duty re-issues as soon as ready returns.
        bus.cmd_valid_i = 1'b1; bus.cmd_target_i = 8'(cur_duty); bus.cmd_step_i = 8'd3; bus.cmd_interval_i = '0;
        found = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            dn[c-1] = bus.done_o;
            if (bus.b_write_o) found = 1'b1;
            if (c == 3) bus.cmd_valid_i = 1'b0;
        end
        check("held_valid_done_pattern", 64'({dn[2], dn[1], dn[0]}), 64'(3'b101));
        check("held_valid_no_strobe", 64'(found), 64'(0));
        @(negedge clk);
        check("held_valid_ready", 64'({bus.cmd_ready_o, bus.done_o}), 64'(2'b10));

        // Reset in the middle of a ramp releases the bus on the next edge.
        bus.cmd_valid_i = 1'b1; bus.cmd_target_i = 8'(cur_duty ^ 8'h80); bus.cmd_step_i = 8'd1; bus.cmd_interval_i = IW'(2);
        found = 1'b0;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) bus.cmd_valid_i = 1'b0;
            if (bus.b_write_o && bus.b_addr_o == DUTY_ADDR) n++;
            if (n == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("midramp_strobe_seen", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midramp_reset", 64'({bus.b_write_o, bus.busy_o, bus.done_o, bus.duty_o, bus.cmd_ready_o}),
              64'({1'b0, 1'b0, 1'b0, INIT_DUTY, 1'b1}));
        rst = 1'b0;
        @(negedge clk);
        cur_duty    = int'(INIT_DUTY);
        cfg_pending = HAS_CFG;
        run(8'h09, 3, 1, -1);

        // Random commands against the model.
        for (int i = 0; i < 40; i++) begin
            tgt = int'($urandom_range(0, 255));
            stp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 255));
            ivl = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            run(tgt, stp, ivl, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
